mt_thread_sched: RTL

- Upstream issue stage of the barrel core; each cycle it picks which hardware thread fetches next.
- Drives the thread-select input of the multithreaded PC bank.
- Round-robin over eligible threads:
  - threads can be disabled by configuration;
  - threads can be parked for N cycles, e.g. while a branch resolves in EX;
  - threads can be halted, e.g. on ecall/ebreak, until explicitly woken.
- Emits a bubble (tid_valid=0) when no thread is eligible.

---
 rtl/mt_thread_sched.sv | 110 +++++++++++
 1 files changed

// File: rtl/mt_thread_sched.sv
// rtl/mt_thread_sched.sv - round-robin hardware-thread issue scheduler with park/halt/wake control
// Optional SCHED_STATS_EN adds a 32-bit bubble_count output.
module mt_thread_sched #(
    parameter int NUM_THREADS = 8,
    parameter int SLEEP_WIDTH = 4,
    localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [NUM_THREADS-1:0]  thread_en,
    input  logic                    park_valid,
    input  logic [BITS_THREADS-1:0] park_tid,
    input  logic [SLEEP_WIDTH-1:0]  park_cycles,
    input  logic                    halt_valid,
    input  logic [BITS_THREADS-1:0] halt_tid,
    input  logic                    wake_valid,
    input  logic [BITS_THREADS-1:0] wake_tid,
    output logic [BITS_THREADS-1:0] tid,
    output logic                    tid_valid,
    output logic [NUM_THREADS-1:0]  halted,
    output logic [NUM_THREADS-1:0]  parked
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]             bubble_count
`endif
);

    logic [SLEEP_WIDTH-1:0]  cnt      [NUM_THREADS];
    logic [SLEEP_WIDTH-1:0]  cnt_next [NUM_THREADS];
    logic [NUM_THREADS-1:0]  halted_next;
    logic [NUM_THREADS-1:0]  parked_next;
    logic [NUM_THREADS-1:0]  elig;
    logic [BITS_THREADS-1:0] last;
    logic [BITS_THREADS-1:0] pick;
    logic [BITS_THREADS-1:0] idx;
    logic                    found;

    // Park beats wake on the counter; halt beats wake on the flag.
    always_comb begin
        halted_next = halted;
        parked_next = '0;
        elig        = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cnt_next[i] = '0;
            if (park_valid && park_tid == BITS_THREADS'(i) && park_cycles != '0)
                cnt_next[i] = park_cycles;
            else if (wake_valid && wake_tid == BITS_THREADS'(i))
                cnt_next[i] = '0;
            else if (cnt[i] != '0)
                cnt_next[i] = cnt[i] - SLEEP_WIDTH'(1);

            if (halt_valid && halt_tid == BITS_THREADS'(i))
                halted_next[i] = 1'b1;
            else if (wake_valid && wake_tid == BITS_THREADS'(i))
                halted_next[i] = 1'b0;

            parked_next[i] = (cnt_next[i] != '0);
            elig[i] = thread_en[i] & ~halted_next[i] & ~parked_next[i];
        end
    end

    // Search starts just after the last grant; the final step wraps onto last itself.
    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = last;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            idx = last + BITS_THREADS'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tid       <= '0;
            tid_valid <= 1'b0;
            last      <= BITS_THREADS'(NUM_THREADS - 1);
            halted    <= '0;
            parked    <= '0;
            for (int i = 0; i < NUM_THREADS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_THREADS; i++)
                cnt[i] <= cnt_next[i];
            halted <= halted_next;
            parked <= parked_next;
            if (!stall) begin
                tid_valid <= found;
                if (found) begin
                    tid  <= pick;
                    last <= pick;
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            bubble_count <= '0;
        else if (!stall && !found)
            bubble_count <= bubble_count + 32'd1;
    end
`endif

endmodule
